fetch_inst_queue: RTL

- Sits between the PC/I-cache fetch stage and the dual decoders (decode1/decode2).
- Accepts one 128-bit fetch line per cycle holding up to 4 RV64 instructions with a per-slot valid mask.
- Compacts the valid slots into a circular FIFO, tagging each instruction with its PC.
- Presents the two oldest entries to the decode lanes; flushes on any redirect.

---
 rtl/fetch_inst_queue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: compacting instruction queue between fetch and the two
// decode lanes. Takes up to four instructions per fetch line (per-slot valid
// mask), packs them into a circular buffer tagged with their PC and presents
// the two oldest entries to decode1/decode2. Any redirect (flush) empties it.
//
// Optional build macro: FETCHQ_PERF_EN adds stall and flush-drop counters.
//
// Handshake: a fetch line is taken at a clock edge when in_valid && in_ready
// && !flush; in_ready depends only on registered occupancy, so a line offered
// while in_ready is low is not taken and upstream must hold it. On the decode
// side lane 0 is consumed when out0_valid && id_ready0, and lane 1 only when
// lane 0 is also consumed (out1_valid && id_ready1), which keeps program order.
module fetch_inst_queue #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [63:0]        in_pc,
   input  logic [127:0]       in_inst,
   input  logic [3:0]         in_mask,
   output logic               in_ready,
   output logic               out0_valid,
   output logic [31:0]        out0_inst,
   output logic [63:0]        out0_pc,
   output logic               out1_valid,
   output logic [31:0]        out1_inst,
   output logic [63:0]        out1_pc,
   input  logic               id_ready0,
   input  logic               id_ready1,
`ifdef FETCHQ_PERF_EN
   output logic [31:0]        perf_stall_cnt,
   output logic [31:0]        perf_flush_drop,
`endif
   output logic [PTR_W:0]     q_count
);

   logic [31:0]      inst_mem [DEPTH];
   logic [63:0]      pc_mem   [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;
   logic [PTR_W-1:0] head_nxt1;
   logic [PTR_W:0]   free_cnt;

   logic             enq;
   logic             deq0;
   logic             deq1;
   logic [2:0]       enq_n;
   logic [1:0]       deq_n;
   logic [3:0][2:0]  slot_off;

   // Low PC bits are replaced by the slot index, so they never reach storage.
   logic             unused_pc_low;
   assign unused_pc_low = ^in_pc[3:0];

   // Occupancy-derived status and handshake terms.
   always_comb begin
      free_cnt   = (PTR_W+1)'(DEPTH) - count;
      in_ready   = (free_cnt >= (PTR_W+1)'(4));
      out0_valid = (count >= (PTR_W+1)'(1));
      out1_valid = (count >= (PTR_W+1)'(2));
      enq        = in_valid && in_ready && !flush;
      deq0       = out0_valid && id_ready0;
      deq1       = deq0 && out1_valid && id_ready1;
      deq_n      = {1'b0, deq0} + {1'b0, deq1};
      q_count    = count;
   end

   // Compaction offsets: each valid slot lands after the valid slots below it.
   always_comb begin
      slot_off[0] = 3'd0;
      slot_off[1] = {2'b00, in_mask[0]};
      slot_off[2] = {2'b00, in_mask[0]} + {2'b00, in_mask[1]};
      slot_off[3] = {2'b00, in_mask[0]} + {2'b00, in_mask[1]} + {2'b00, in_mask[2]};
      enq_n       = enq ? (slot_off[3] + {2'b00, in_mask[3]}) : 3'd0;
   end

   // Lane outputs read straight from storage, forced to zero when invalid.
   always_comb begin
      head_nxt1 = head + PTR_W'(1);
      out0_inst = out0_valid ? inst_mem[head]      : 32'd0;
      out0_pc   = out0_valid ? pc_mem[head]        : 64'd0;
      out1_inst = out1_valid ? inst_mem[head_nxt1] : 32'd0;
      out1_pc   = out1_valid ? pc_mem[head_nxt1]   : 64'd0;
   end

   // Write valid slots of an accepted line into consecutive entries at tail.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (enq && in_mask[i]) begin
            inst_mem[tail + PTR_W'(slot_off[i])] <= in_inst[32*i +: 32];
            pc_mem[tail + PTR_W'(slot_off[i])]   <= {in_pc[63:4], 2'(i), 2'b00};
         end
      end
   end

   // Pointer and occupancy update; reset beats flush, flush beats traffic.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(deq_n);
         tail  <= tail + PTR_W'(enq_n);
         count <= count + (PTR_W+1)'(enq_n) - (PTR_W+1)'(deq_n);
      end
   end

`ifdef FETCHQ_PERF_EN
   logic [32:0] drop_sum;
   assign drop_sum = {1'b0, perf_flush_drop} + 33'(count);

   // Saturating counters for stalled fetch lines and entries lost to flushes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_stall_cnt  <= 32'd0;
         perf_flush_drop <= 32'd0;
      end else begin
         if (in_valid && !in_ready && !flush && (perf_stall_cnt != 32'hFFFF_FFFF))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (flush)
            perf_flush_drop <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
      end
   end
`endif

endmodule
